// File: rtl/bht_if.sv
// Lookup / update bundle between the fetch+execute pipeline (master) and the branch history table (slave).
interface bht_if #(
  parameter int ADDR_W = 32
);
  logic              en;
  logic              flush;
  logic [ADDR_W-1:0] pc_if;
  logic              pred_hit;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic [1:0]        pred_state;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic [1:0]        upd_state;
  logic              upd_hit;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              ready;

  modport master (
    output en, flush, pc_if, upd_valid, upd_pc, upd_state, upd_hit, upd_taken, upd_target,
    input  pred_hit, pred_taken, pred_target, pred_state, ready
  );

  modport slave (
    input  en, flush, pc_if, upd_valid, upd_pc, upd_state, upd_hit, upd_taken, upd_target,
    output pred_hit, pred_taken, pred_target, pred_state, ready
  );
endinterface

// File: rtl/bht_predict_update.sv
// Direct-mapped, tagged branch history table with 2-bit saturating counters and stored targets.
// A sweep FSM invalidates every entry after reset or flush before the table reports ready.
module bht_predict_update #(
  parameter int         INDEX_W     = 6,
  parameter int         TAG_W       = 8,
  parameter int         ADDR_W      = 32,
  parameter logic [1:0] ALLOC_STATE = 2'b10
) (
  input  logic clk,
  input  logic rst_n,
  bht_if.slave bus
);
  localparam int DEPTH = 1 << INDEX_W;

  typedef enum logic {SWEEP, RUN} fsm_t;

  fsm_t               fsm;
  logic [INDEX_W-1:0] sweep_idx;
  logic               ready_r;
  logic [DEPTH-1:0]   valid;

  logic [TAG_W-1:0]   tag_mem [DEPTH];
  logic [ADDR_W-1:0]  tgt_mem [DEPTH];
  logic [1:0]         ctr_mem [DEPTH];

  function automatic logic [1:0] sat_next(input logic [1:0] s, input logic taken);
    if (taken) return (s == 2'b11) ? s : s + 2'd1;
    return (s == 2'b00) ? s : s - 2'd1;
  endfunction

  // Lookup reads the registered table; gating on ready_r hides stale entries during the sweep.
  logic [INDEX_W-1:0] lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic               lk_hit;

  assign lk_idx = bus.pc_if[INDEX_W+1:2];
  assign lk_tag = bus.pc_if[INDEX_W+TAG_W+1:INDEX_W+2];
  assign lk_hit = ready_r & valid[lk_idx] & (tag_mem[lk_idx] == lk_tag);

  assign bus.pred_hit    = lk_hit;
  assign bus.pred_taken  = lk_hit & ctr_mem[lk_idx][1];
  assign bus.pred_target = lk_hit ? tgt_mem[lk_idx] : '0;
  assign bus.pred_state  = lk_hit ? ctr_mem[lk_idx] : 2'b00;
  assign bus.ready       = ready_r;

  // A carried hit only counts if the entry still belongs to this branch.
  logic [INDEX_W-1:0] up_idx;
  logic [TAG_W-1:0]   up_tag;
  logic               up_go;
  logic               up_match;

  assign up_idx   = bus.upd_pc[INDEX_W+1:2];
  assign up_tag   = bus.upd_pc[INDEX_W+TAG_W+1:INDEX_W+2];
  assign up_go    = ready_r & bus.en & bus.upd_valid & ~bus.flush;
  assign up_match = bus.upd_hit & valid[up_idx] & (tag_mem[up_idx] == up_tag);

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.pc_if[1:0], bus.pc_if[ADDR_W-1:INDEX_W+TAG_W+2],
                            bus.upd_pc[1:0], bus.upd_pc[ADDR_W-1:INDEX_W+TAG_W+2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= SWEEP;
      sweep_idx <= '0;
      ready_r   <= 1'b0;
      valid     <= '0;
    end else if (bus.flush) begin
      fsm       <= SWEEP;
      sweep_idx <= '0;
      ready_r   <= 1'b0;
    end else begin
      case (fsm)
        SWEEP: begin
          valid[sweep_idx] <= 1'b0;
          sweep_idx        <= sweep_idx + 1'b1;
          if (sweep_idx == INDEX_W'(DEPTH - 1)) begin
            fsm     <= RUN;
            ready_r <= 1'b1;
          end
        end
        RUN: begin
          if (up_go && !up_match && bus.upd_taken) valid[up_idx] <= 1'b1;
        end
        default: begin
          fsm     <= SWEEP;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  // Entry payload carries no reset; valid alone decides whether it is visible.
  always_ff @(posedge clk) begin
    if (up_go) begin
      if (up_match) begin
        ctr_mem[up_idx] <= sat_next(bus.upd_state, bus.upd_taken);
        if (bus.upd_taken) tgt_mem[up_idx] <= bus.upd_target;
      end else if (bus.upd_taken) begin
        tag_mem[up_idx] <= up_tag;
        tgt_mem[up_idx] <= bus.upd_target;
        ctr_mem[up_idx] <= ALLOC_STATE;
      end
    end
  end
endmodule
